// File: rtl/chacha20_stream_xor_if.sv
// Handshake bundle for chacha20_stream_xor: session control, data in/out streams
// and the keystream request channel toward the chacha20 core wrapper.
interface chacha20_stream_xor_if;
  logic         start;
  logic [31:0]  init_count;
  logic         busy;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic         ks_req;
  logic [31:0]  ks_count;
  logic         ks_valid;
  logic [511:0] ks_data;
  logic         wrap_err;

  modport master (
    output start, init_count, in_data, in_valid, in_last, out_ready, ks_valid, ks_data,
    input  busy, in_ready, out_data, out_valid, out_last, ks_req, ks_count, wrap_err
  );

  modport slave (
    input  start, init_count, in_data, in_valid, in_last, out_ready, ks_valid, ks_data,
    output busy, in_ready, out_data, out_valid, out_last, ks_req, ks_count, wrap_err
  );
endinterface

// File: rtl/chacha20_stream_xor.sv
// Stream XOR front end for a chacha20 core: fetches 512-bit keystream blocks with an
// incrementing counter and XORs each 32-bit data word against them in RFC 8439 byte order.
module chacha20_stream_xor #(
  parameter int WORDS_PER_BLOCK = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  chacha20_stream_xor_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_BLOCK - 1);

  state_t       state_q, state_d;
  logic [31:0]  ctr_q;
  logic [511:0] ks_buf_q;
  logic [3:0]   idx_q;
  logic         wrap_err_q;
  logic [31:0]  out_data_q;
  logic         out_valid_q;
  logic         out_last_q;

  logic in_ready_c;
  logic accept;
  logic block_end;
  logic ctr_at_max;

  assign accept     = bus.in_valid && in_ready_c;
  assign block_end  = accept && !bus.in_last && (idx_q == LAST_IDX);
  assign ctr_at_max = (ctr_q == 32'hFFFF_FFFF);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    unique case (state_q)
      IDLE:   if (bus.start) state_d = REQ;
      REQ:    state_d = WAIT;
      WAIT:   if (bus.ks_valid) state_d = STREAM;
      STREAM: begin
        // One-deep output register: take a new word whenever the slot is free or draining.
        in_ready_c = !out_valid_q || bus.out_ready;
        if (accept) begin
          if (bus.in_last)   state_d = DRAIN;
          else if (block_end) state_d = ctr_at_max ? DRAIN : REQ;
        end
      end
      DRAIN:  if (!out_valid_q || bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ctr_q       <= '0;
      // NOTE: the keystream buffer is reset on purpose so an aborted session leaves no key material behind.
      ks_buf_q    <= '0;
      idx_q       <= '0;
      wrap_err_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && bus.start) begin
        ctr_q      <= bus.init_count;
        wrap_err_q <= 1'b0;
      end

      if (state_q == WAIT && bus.ks_valid) begin
        ks_buf_q <= bus.ks_data;
        idx_q    <= '0;
      end

      // The buffer shifts up one word per accept, so the current word is always the top slice.
      if (accept) begin
        out_data_q  <= bus.in_data ^ ks_buf_q[511:480];
        out_last_q  <= bus.in_last;
        out_valid_q <= 1'b1;
        ks_buf_q    <= {ks_buf_q[479:0], 32'h0};
        idx_q       <= idx_q + 4'd1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (block_end) begin
        if (ctr_at_max) wrap_err_q <= 1'b1;
        else            ctr_q      <= ctr_q + 32'd1;
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.ks_req    = (state_q == REQ);
  assign bus.ks_count  = ctr_q;
  assign bus.wrap_err  = wrap_err_q;

endmodule

// File: tb/tb_chacha20_stream_xor.sv
// Self-checking bench for chacha20_stream_xor: a keystream responder model plus an
// output scoreboard fed at input-accept time.
module tb_chacha20_stream_xor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chacha20_stream_xor_if bus ();

  chacha20_stream_xor #(.WORDS_PER_BLOCK(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  logic hold = 1'b0;

  logic [32:0] sb[$];       // {last, data} expected on the output stream
  logic [31:0] exp_cnt[$];  // expected ks_count per ks_req

  // Keystream model: block 1 carries the RFC 8439 2.4.2 words the vectors rely on.
  function automatic logic [31:0] ks_word(input logic [31:0] cnt, input int i);
    if (cnt == 32'd1 && i == 0)  return 32'h224f51f3;
    if (cnt == 32'd1 && i == 1)  return 32'h401bd9e1;
    if (cnt == 32'd1 && i == 15) return 32'hf07d41b7;
    return (cnt * 32'h9e3779b1) ^ (32'(i) * 32'h85ebca6b) ^ 32'h5bd1e995;
  endfunction

  function automatic logic [511:0] ks_block(input logic [31:0] cnt);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = ks_word(cnt, i);
    return b;
  endfunction

  function automatic logic [68:0] all_outs();
    return {bus.busy, bus.in_ready, bus.out_data, bus.out_valid, bus.out_last,
            bus.ks_req, bus.ks_count, bus.wrap_err};
  endfunction

  // Keystream core stand-in: answers each request three cycles later with a one-cycle pulse.
  initial begin
    logic [511:0] blk;
    forever begin
      @(negedge clk);
      if (bus.ks_req === 1'b1) begin
        checks++;
        if (exp_cnt.size() == 0) begin
          errors++;
          $display("FAIL ks_req_unexpected: got ks_count=%h, required no request", bus.ks_count);
        end else begin
          logic [31:0] e;
          e = exp_cnt.pop_front();
          if (bus.ks_count !== e) begin
            errors++;
            $display("FAIL ks_count: got %h, required %h", bus.ks_count, e);
          end
        end
        blk = ks_block(bus.ks_count);
        repeat (3) @(negedge clk);
        bus.ks_data  = blk;
        bus.ks_valid = 1'b1;
        @(negedge clk);
        bus.ks_valid = 1'b0;
      end
    end
  end

  // Output sink: drives out_ready and compares each handshaked word with the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      bus.out_ready = !hold;
      #2;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        n_out++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got data=%h last=%b, required no output", bus.out_data, bus.out_last);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          if ({bus.out_last, bus.out_data} !== e) begin
            errors++;
            $display("FAIL out_word: got last=%b data=%h, required last=%b data=%h",
                     bus.out_last, bus.out_data, e[32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] cnt);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.init_count = cnt;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  // Presents n random words; pushes the expected ciphertext on each accept.
  task automatic send_words(input int n, input int last_idx, input logic [31:0] init,
                            input int budget, output int acc);
    int cyc;
    logic [31:0] cur;
    acc = 0;
    cyc = 0;
    cur = $urandom;
    while (acc < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      bus.in_valid = 1'b1;
      bus.in_data  = cur;
      bus.in_last  = (acc == last_idx);
      #1;
      if (bus.in_ready === 1'b1) begin
        sb.push_back({bus.in_last, cur ^ ks_word(init + 32'(acc / 16), acc % 16)});
        acc++;
        cur = $urandom;
      end
    end
    if (acc == n) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while ((bus.busy !== 1'b0 || bus.out_valid !== 1'b0) && cyc < 200) begin
      @(negedge clk);
      #3;
      cyc++;
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: got busy=%b out_valid=%b, required 0 0", tag, bus.busy, bus.out_valid);
    end
    checks++;
    if (sb.size() != 0 || exp_cnt.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d outputs and %0d requests outstanding, required 0 0",
               tag, sb.size(), exp_cnt.size());
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", all_outs());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rfc_vector(input string tag);
    int cyc;
    exp_cnt.push_back(32'd1);
    do_start(32'd1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got %b, required 1", tag, bus.busy);
    end
    cyc = 0;
    bus.in_data  = 32'h4c616469;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (bus.in_ready !== 1'b1 && cyc < 30);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept_timeout: got in_ready=%b, required 1", tag, bus.in_ready);
    end
    sb.push_back({1'b1, 32'h6e2e359a});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h6e2e359a || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: got valid=%b data=%h last=%b, required 1 6e2e359a 1",
               tag, bus.out_valid, bus.out_data, bus.out_last);
    end
    wait_idle(tag);
  endtask

  task automatic test_two_blocks();
    int acc;
    exp_cnt.push_back(32'd1);
    exp_cnt.push_back(32'd2);
    n_out = 0;
    do_start(32'd1);
    send_words(20, 19, 32'd1, 200, acc);
    checks++;
    if (acc != 20) begin
      errors++;
      $display("FAIL two_blocks_accepted: got %0d, required 20", acc);
    end
    wait_idle("two_blocks");
    checks++;
    if (n_out != 20) begin
      errors++;
      $display("FAIL two_blocks_count: got %0d outputs, required 20", n_out);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [31:0] snap;
    exp_cnt.push_back(32'd5);
    n_out = 0;
    do_start(32'd5);
    fork
      send_words(10, 9, 32'd5, 200, acc);
      begin
        int cyc;
        cyc = 0;
        while (n_out < 3 && cyc < 100) begin
          @(negedge clk);
          cyc++;
        end
        @(posedge clk);
        #1;
        hold = 1'b1;
        @(negedge clk);
        #1;
        snap = bus.out_data;
        checks++;
        if (bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_valid_held: got %b, required 1", bus.out_valid);
        end
        repeat (4) begin
          @(negedge clk);
          #1;
          checks++;
          if (bus.in_ready !== 1'b0 || bus.out_data !== snap) begin
            errors++;
            $display("FAIL bp_stall: got in_ready=%b data=%h, required 0 %h", bus.in_ready, bus.out_data, snap);
          end
        end
        @(posedge clk);
        #1;
        hold = 1'b0;
      end
    join
    checks++;
    if (acc != 10) begin
      errors++;
      $display("FAIL bp_accepted: got %0d, required 10", acc);
    end
    wait_idle("backpressure");
    checks++;
    if (n_out != 10) begin
      errors++;
      $display("FAIL bp_count: got %0d outputs, required 10", n_out);
    end
  endtask

  task automatic test_wrap();
    int acc;
    exp_cnt.push_back(32'hFFFF_FFFF);
    n_out = 0;
    do_start(32'hFFFF_FFFF);
    send_words(17, 16, 32'hFFFF_FFFF, 80, acc);
    checks++;
    if (acc != 16) begin
      errors++;
      $display("FAIL wrap_accepted: got %0d, required 16", acc);
    end
    wait_idle("wrap");
    checks++;
    if (bus.wrap_err !== 1'b1 || n_out != 16) begin
      errors++;
      $display("FAIL wrap_err: got wrap_err=%b outputs=%0d, required 1 16", bus.wrap_err, n_out);
    end
  endtask

  task automatic test_early_last();
    int acc;
    exp_cnt.push_back(32'd1);
    do_start(32'd1);
    send_words(3, 2, 32'd1, 100, acc);
    wait_idle("early_last");
    checks++;
    if (bus.wrap_err !== 1'b0) begin
      errors++;
      $display("FAIL early_last_wrap_clear: got %b, required 0", bus.wrap_err);
    end
    exp_cnt.push_back(32'd7);
    do_start(32'd7);
    send_words(4, 3, 32'd7, 100, acc);
    checks++;
    if (acc != 4) begin
      errors++;
      $display("FAIL restart_accepted: got %0d, required 4", acc);
    end
    wait_idle("restart");
  endtask

  task automatic test_reset_abort();
    int acc;
    // Abort while waiting for the keystream block.
    exp_cnt.push_back(32'd1);
    do_start(32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_in_wait: got %h, required 0", all_outs());
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    // Abort mid-stream with an output word still pending.
    exp_cnt.push_back(32'd1);
    do_start(32'd1);
    send_words(2, -1, 32'd1, 60, acc);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_in_stream: got %h, required 0", all_outs());
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    test_rfc_vector("rfc_after_reset");
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.init_count = '0;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b1;
    bus.ks_valid   = 1'b0;
    bus.ks_data    = '0;
    test_reset();
    test_rfc_vector("rfc");
    test_two_blocks();
    test_backpressure();
    test_wrap();
    test_early_last();
    test_reset_abort();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
